snn_inference_sequencer: RTL and testbench



---
 rtl/snn_seq_pkg.sv | 16 +
 rtl/snn_sat_counter.sv | 26 ++
 rtl/snn_inference_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_snn_inference_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_seq_pkg.sv
// Shared state encoding and network geometry for the SNN inference sequencer.
package snn_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_FIRE  = 3'd2,
      S_WAIT  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam int NET_LATENCY = 3;
   localparam int N_IN        = 8;
   localparam int N_OUT       = 2;

endpackage

// File: rtl/snn_sat_counter.sv
// Per-class spike counter: synchronous clear, single-step increment, saturates at all-ones.
module snn_sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_clear,
   input  logic         i_inc,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_inc && (r_count != '1)) begin
         r_count <= r_count + W'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/snn_inference_sequencer.sv
// Sequences one SNN inference over num_steps timesteps and reports the winning class.
// Optional watchdog on the network response is enabled by defining SNN_SEQ_WATCHDOG_EN.
//
// state   | meaning
// IDLE    | waiting for start; counters hold last result
// FETCH   | in_ready high, waiting for an input frame
// FIRE    | one-cycle net_enable (and divided net_delay_clk) pulse
// WAIT    | waiting for net_data_ready, then accumulate spikes
// DONE    | result_valid high until result_ready
module snn_inference_sequencer
   import snn_seq_pkg::*;
#(
   parameter int STEPS_W     = 8,
   parameter int CNT_W       = 8,
   parameter int DELAY_DIV   = 1,
   parameter int TIMEOUT_CYC = 15
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [STEPS_W-1:0] num_steps,
   input  logic               in_valid,
   input  logic [N_IN-1:0]    in_spikes,
   output logic               in_ready,
   output logic               net_enable,
   output logic               net_delay_clk,
   output logic [N_IN-1:0]    net_input_spikes,
   input  logic [N_OUT-1:0]   net_output_spikes,
   input  logic               net_data_ready,
   output logic               result_valid,
   input  logic               result_ready,
   output logic               result_class,
   output logic               result_tie,
   output logic [CNT_W-1:0]   count0,
   output logic [CNT_W-1:0]   count1,
`ifdef SNN_SEQ_WATCHDOG_EN
   output logic               timeout_err,
`endif
   output logic               busy
);

   localparam int DIV_W = (DELAY_DIV > 1) ? $clog2(DELAY_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DELAY_DIV - 1);

   if (DELAY_DIV < 1 || TIMEOUT_CYC < 1) begin : g_param_check
      $error("snn_inference_sequencer: DELAY_DIV and TIMEOUT_CYC must be >= 1");
   end

   state_t              r_state;
   state_t              w_next;
   logic [STEPS_W-1:0]  r_num_steps;
   logic [STEPS_W-1:0]  r_step_cnt;
   logic [DIV_W-1:0]    r_div;
   logic                r_net_enable;
   logic                r_net_delay_clk;
   logic [N_IN-1:0]     r_in_spikes;
   logic                w_clear;
   logic                w_acc;
   logic                w_last;
   logic                w_done;

   assign w_clear = (r_state == S_IDLE) && start;
   assign w_acc   = (r_state == S_WAIT) && net_data_ready;
   // Extra bit so a num_steps of all-ones cannot wrap the terminal compare.
   assign w_last  = (({1'b0, r_step_cnt} + (STEPS_W + 1)'(1)) == {1'b0, r_num_steps});
   assign w_done  = (r_state == S_DONE);

`ifdef SNN_SEQ_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   logic [WD_W-1:0] r_wd_cnt;
   logic            r_timeout_err;
   logic            w_wd_expire;

   assign w_wd_expire = (r_state == S_WAIT) && !net_data_ready &&
                        (r_wd_cnt == WD_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wd_cnt      <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_wd_cnt <= (r_state == S_WAIT) ? r_wd_cnt + WD_W'(1) : '0;
         if (w_clear) begin
            r_timeout_err <= 1'b0;
         end else if (w_wd_expire) begin
            r_timeout_err <= 1'b1;
         end
      end
   end

   assign timeout_err = r_timeout_err;
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next = (num_steps == '0) ? S_DONE : S_FETCH;
            end
         end
         S_FETCH: begin
            if (in_valid) begin
               w_next = S_FIRE;
            end
         end
         S_FIRE: w_next = S_WAIT;
         S_WAIT: begin
            if (net_data_ready) begin
               w_next = w_last ? S_DONE : S_FETCH;
            end
`ifdef SNN_SEQ_WATCHDOG_EN
            else if (w_wd_expire) begin
               w_next = S_DONE;
            end
`endif
         end
         S_DONE: begin
            if (result_ready) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= S_IDLE;
         r_num_steps     <= '0;
         r_step_cnt      <= '0;
         r_div           <= '0;
         r_net_enable    <= 1'b0;
         r_net_delay_clk <= 1'b0;
         r_in_spikes     <= '0;
      end else begin
         r_state         <= w_next;
         // Pulses are registered on entry so they line up exactly with FIRE.
         r_net_enable    <= (w_next == S_FIRE);
         r_net_delay_clk <= (w_next == S_FIRE) && (r_div == '0);
         if (w_clear) begin
            r_num_steps <= num_steps;
            r_step_cnt  <= '0;
            r_div       <= '0;
         end
         if ((r_state == S_FETCH) && in_valid) begin
            r_in_spikes <= in_spikes;
         end
         if (r_state == S_FIRE) begin
            r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
         end
         if (w_acc) begin
            r_step_cnt <= r_step_cnt + STEPS_W'(1);
         end
      end
   end

   snn_sat_counter #(.W(CNT_W)) u_cnt0 (
      .clk     (clk),
      .reset   (reset),
      .i_clear (w_clear),
      .i_inc   (w_acc && net_output_spikes[0]),
      .o_count (count0)
   );

   snn_sat_counter #(.W(CNT_W)) u_cnt1 (
      .clk     (clk),
      .reset   (reset),
      .i_clear (w_clear),
      .i_inc   (w_acc && net_output_spikes[1]),
      .o_count (count1)
   );

   assign in_ready         = (r_state == S_FETCH);
   assign busy             = (r_state != S_IDLE);
   assign result_valid     = w_done;
   assign result_class     = w_done && (count1 > count0);
   assign result_tie       = w_done && (count0 == count1);
   assign net_enable       = r_net_enable;
   assign net_delay_clk    = r_net_delay_clk;
   assign net_input_spikes = r_in_spikes;

endmodule

// File: tb/tb_snn_inference_sequencer.sv
// Directed bench for snn_inference_sequencer with a fixed-latency network model.
module tb_snn_inference_sequencer;
   import snn_seq_pkg::*;

   localparam int STEPS_W = 8;
   localparam int CNT_W   = 3;

   logic               clk = 1'b0;
   logic               reset;
   logic               start;
   logic [STEPS_W-1:0] num_steps;
   logic               in_valid;
   logic [7:0]         in_spikes;
   logic               in_ready;
   logic               net_enable;
   logic               net_delay_clk;
   logic [7:0]         net_input_spikes;
   logic [1:0]         net_output_spikes;
   logic               net_data_ready;
   logic               result_valid;
   logic               result_ready;
   logic               result_class;
   logic               result_tie;
   logic [CNT_W-1:0]   count0;
   logic [CNT_W-1:0]   count1;
   logic               busy;
`ifdef SNN_SEQ_WATCHDOG_EN
   logic               timeout_err;
`endif

   int checks   = 0;
   int failures = 0;

   logic [1:0]  model_out = 2'b00;
   logic        model_en  = 1'b1;
   logic [NET_LATENCY-1:0] pipe = '0;
   int          en_cnt    = 0;
   int          stray_dly = 0;
   logic [63:0] dly_hist  = '0;

   always #5 clk = ~clk;

   snn_inference_sequencer #(
      .STEPS_W(STEPS_W), .CNT_W(CNT_W), .DELAY_DIV(3), .TIMEOUT_CYC(15)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .num_steps(num_steps),
      .in_valid(in_valid), .in_spikes(in_spikes), .in_ready(in_ready),
      .net_enable(net_enable), .net_delay_clk(net_delay_clk),
      .net_input_spikes(net_input_spikes), .net_output_spikes(net_output_spikes),
      .net_data_ready(net_data_ready), .result_valid(result_valid),
      .result_ready(result_ready), .result_class(result_class),
      .result_tie(result_tie), .count0(count0), .count1(count1),
`ifdef SNN_SEQ_WATCHDOG_EN
      .timeout_err(timeout_err),
`endif
      .busy(busy)
   );

   // Network model: data-ready pulse NET_LATENCY cycles after each enable pulse.
   always @(posedge clk) begin
      pipe <= {pipe[NET_LATENCY-2:0], net_enable};
      if (net_enable) begin
         en_cnt   <= en_cnt + 1;
         dly_hist <= {dly_hist[62:0], net_delay_clk};
      end else if (net_delay_clk) begin
         stray_dly <= stray_dly + 1;
      end
   end
   assign net_data_ready    = pipe[NET_LATENCY-1] & model_en;
   assign net_output_spikes = model_out;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start_inf(input logic [7:0] n);
      start = 1'b1; num_steps = n;
      tick();
      start = 1'b0;
   endtask

   task automatic feed(input int nframes, input logic [7:0] frame);
      for (int k = 0; k < nframes; k++) begin
         int t = 0;
         while (!in_ready && t < 200) begin tick(); t++; end
         if (t >= 200) chk("fetch_timeout", 32'(t), 32'd0);
         in_valid = 1'b1; in_spikes = frame;
         tick();
         in_valid = 1'b0;
      end
   endtask

   task automatic wait_result();
      int t = 0;
      while (!result_valid && t < 200) begin tick(); t++; end
      if (t >= 200) chk("result_timeout", 32'(t), 32'd0);
   endtask

   task automatic consume();
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
   endtask

   initial begin
      int base;
      reset = 1'b1; start = 1'b0; num_steps = '0; in_valid = 1'b0;
      in_spikes = '0; result_ready = 1'b0;
      repeat (3) tick();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rv", 32'(result_valid), 0);
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_en", 32'(net_enable), 0);
      chk("rst_dly", 32'(net_delay_clk), 0);
      chk("rst_tie", 32'(result_tie), 0);
      chk("rst_cnt0", 32'(count0), 0);
      chk("rst_spk", 32'(net_input_spikes), 0);
      reset = 1'b0;
      tick();

      // Reset mid-WAIT at step 2 of 5
      model_out = 2'b11;
      start_inf(8'd5);
      feed(2, 8'h5A);
      feed(1, 8'h3C);
      tick();
      chk("mid_cnt0", 32'(count0), 2);
      chk("mid_busy", 32'(busy), 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_cnt0", 32'(count0), 0);
      chk("abort_cnt1", 32'(count1), 0);
      chk("abort_rv", 32'(result_valid), 0);
      repeat (5) tick();
      chk("late_ready_cnt0", 32'(count0), 0);
      chk("late_ready_busy", 32'(busy), 0);

      // 4 steps, class 0 only
      model_out = 2'b01;
      base = en_cnt;
      start_inf(8'd4);
      feed(4, 8'hFF);
      wait_result();
      chk("s4_cnt0", 32'(count0), 4);
      chk("s4_cnt1", 32'(count1), 0);
      chk("s4_class", 32'(result_class), 0);
      chk("s4_tie", 32'(result_tie), 0);
      chk("s4_pulses", 32'(en_cnt - base), 4);
      chk("s4_frame", 32'(net_input_spikes), 32'hFF);
      consume();
      chk("s4_idle", 32'(busy), 0);
      chk("s4_hold", 32'(count0), 4);

      // num_steps = 0
      base = en_cnt;
      start_inf(8'd0);
      chk("z_rv", 32'(result_valid), 1);
      chk("z_tie", 32'(result_tie), 1);
      chk("z_class", 32'(result_class), 0);
      chk("z_cnt0", 32'(count0), 0);
      chk("z_pulses", 32'(en_cnt - base), 0);
      consume();

      // Saturation at 7
      model_out = 2'b11;
      start_inf(8'd10);
      feed(10, 8'h01);
      wait_result();
      chk("sat_cnt0", 32'(count0), 7);
      chk("sat_cnt1", 32'(count1), 7);
      chk("sat_tie", 32'(result_tie), 1);
      chk("sat_class", 32'(result_class), 0);
      consume();

      // Class 1 wins
      model_out = 2'b10;
      start_inf(8'd3);
      feed(3, 8'h81);
      wait_result();
      chk("c1_cnt1", 32'(count1), 3);
      chk("c1_class", 32'(result_class), 1);
      chk("c1_tie", 32'(result_tie), 0);
      consume();

      // Delay divider by 3 over 7 steps: pulses at steps 0, 3, 6
      model_out = 2'b00;
      start_inf(8'd7);
      feed(7, 8'h10);
      wait_result();
      chk("div_hist", 32'(dly_hist[6:0]), 32'h49);
      chk("div_stray", 32'(stray_dly), 0);
      chk("div_tie", 32'(result_tie), 1);
      consume();

      // Backpressure on both handshakes; start ignored outside IDLE
      model_out = 2'b01;
      start_inf(8'd2);
      base = en_cnt;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin start = 1'b1; num_steps = 8'd1; end
         tick();
         start = 1'b0;
      end
      chk("bp_in_ready", 32'(in_ready), 1);
      chk("bp_no_en", 32'(en_cnt - base), 0);
      feed(2, 8'hA5);
      wait_result();
      for (int i = 0; i < 4; i++) begin
         chk("bp_rv_held", 32'(result_valid), 1);
         chk("bp_cnt0_held", 32'(count0), 2);
         chk("bp_class_held", 32'(result_class), 0);
         tick();
      end
      consume();
      chk("bp_idle", 32'(busy), 0);

`ifdef SNN_SEQ_WATCHDOG_EN
      begin
         int t = 0;
         model_en = 1'b0;
         start_inf(8'd3);
         feed(1, 8'h11);
         while (!result_valid && t < 100) begin tick(); t++; end
         chk("wd_cycles", 32'(t), 16);
         chk("wd_err", 32'(timeout_err), 1);
         chk("wd_cnt0", 32'(count0), 0);
         consume();
         chk("wd_err_sticky", 32'(timeout_err), 1);
         start_inf(8'd0);
         chk("wd_err_clr", 32'(timeout_err), 0);
         consume();
         model_en = 1'b1;
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
